// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating bubble counter.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [1:0]  id_wb,
   input  logic [2:0]  id_mem,
   input  logic [3:0]  id_ex,
   input  logic [31:0] id_npc,
   input  logic [31:0] id_rd1,
   input  logic [31:0] id_rd2,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   output logic [1:0]  ex_wb,
   output logic [2:0]  ex_mem,
   output logic [3:0]  ex_ex,
   output logic [31:0] ex_npc,
   output logic [31:0] ex_rd1,
   output logic [31:0] ex_rd2,
   output logic [31:0] ex_imm,
   output logic [4:0]  ex_rt,
   output logic [4:0]  ex_rd,
   output logic        ex_valid,
   output logic        load_use,
   output logic        pc_write,
   output logic        ifid_write,
   output logic [15:0] bubble_cnt
);

   typedef struct packed {
      logic [1:0] wb;
      logic [2:0] mem;
      logic [3:0] ex;
   } ctrl_t;

   ctrl_t ctrl_raw, ctrl_s;
   logic  bubble;

   assign ctrl_raw = '{wb: id_wb, mem: id_mem, ex: id_ex};

   // Only a definite 1 is latched; X/Z control bits become 0.
   always_comb begin
      ctrl_s = '0;
      for (int i = 0; i < $bits(ctrl_t); i++)
         ctrl_s[i] = (ctrl_raw[i] === 1'b1);
   end

   assign load_use   = ex_valid & ex_mem[1] & (ex_rt != 5'd0) &
                       ((ex_rt == id_rs) | (ex_rt == id_rt));
   assign pc_write   = ~load_use & ~stall;
   assign ifid_write = ~load_use & ~stall;
   assign bubble     = flush | load_use;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_wb      <= '0;
         ex_mem     <= '0;
         ex_ex      <= '0;
         ex_npc     <= '0;
         ex_rd1     <= '0;
         ex_rd2     <= '0;
         ex_imm     <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
         ex_valid   <= 1'b0;
         bubble_cnt <= '0;
      end else if (!stall) begin
         // Data and specifiers load even on a bubble; only control is squashed.
         ex_npc <= id_npc;
         ex_rd1 <= id_rd1;
         ex_rd2 <= id_rd2;
         ex_imm <= id_imm;
         ex_rt  <= id_rt;
         ex_rd  <= id_rd;
         if (bubble) begin
            ex_wb    <= '0;
            ex_mem   <= '0;
            ex_ex    <= '0;
            ex_valid <= 1'b0;
            if (bubble_cnt != 16'hFFFF)
               bubble_cnt <= bubble_cnt + 16'd1;
         end else begin
            ex_wb    <= ctrl_s.wb;
            ex_mem   <= ctrl_s.mem;
            ex_ex    <= ctrl_s.ex;
            ex_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load, load-use bubble, stall precedence,
// X sanitizing, counter saturation and reset override.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic [1:0]  id_wb;
   logic [2:0]  id_mem;
   logic [3:0]  id_ex;
   logic [31:0] id_npc, id_rd1, id_rd2, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [1:0]  ex_wb;
   logic [2:0]  ex_mem;
   logic [3:0]  ex_ex;
   logic [31:0] ex_npc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]  ex_rt, ex_rd;
   logic        ex_valid, load_use, pc_write, ifid_write;
   logic [15:0] bubble_cnt;

   int checks = 0;
   int errors = 0;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .id_wb(id_wb), .id_mem(id_mem), .id_ex(id_ex),
      .id_npc(id_npc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .ex_wb(ex_wb), .ex_mem(ex_mem), .ex_ex(ex_ex),
      .ex_npc(ex_npc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_valid(ex_valid),
      .load_use(load_use), .pc_write(pc_write), .ifid_write(ifid_write),
      .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      id_wb = '0; id_mem = '0; id_ex = '0;
      id_npc = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
      id_rs = '0; id_rt = '0; id_rd = '0;
      step();
      chk("rst_wb", ex_wb, 0);
      chk("rst_valid", ex_valid, 0);
      chk("rst_cnt", bubble_cnt, 0);
      chk("rst_rd1", ex_rd1, 0);
      chk("rst_lu", load_use, 0);
      chk("rst_pcw", pc_write, 1);
      rst = 1'b0;

      // R-type load
      id_wb = 2'b01; id_mem = 3'b000; id_ex = 4'b1001;
      id_npc = 32'h4; id_rd1 = 32'h11; id_rd2 = 32'h22; id_imm = 32'h33;
      id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
      step();
      chk("r_wb", ex_wb, 2'b01);
      chk("r_ex", ex_ex, 4'b1001);
      chk("r_rd1", ex_rd1, 32'h11);
      chk("r_valid", ex_valid, 1);
      chk("r_rd", ex_rd, 3);
      chk("r_npc", ex_npc, 32'h4);
      chk("r_imm", ex_imm, 32'h33);
      chk("r_cnt", bubble_cnt, 0);

      // LW rt=5 into EX, dependent instruction in ID via rs
      id_wb = 2'b11; id_mem = 3'b010; id_rt = 5'd5; id_rs = 5'd1;
      step();
      chk("lw_mem", ex_mem, 3'b010);
      chk("lw_rt", ex_rt, 5);
      id_wb = 2'b01; id_mem = 3'b000; id_rs = 5'd5; id_rt = 5'd7; id_rd1 = 32'h55;
      #1;
      chk("lu_hit", load_use, 1);
      chk("lu_pcw", pc_write, 0);
      chk("lu_ifw", ifid_write, 0);
      step();
      chk("bub_mem", ex_mem, 0);
      chk("bub_wb", ex_wb, 0);
      chk("bub_valid", ex_valid, 0);
      chk("bub_cnt", bubble_cnt, 1);
      chk("bub_rt", ex_rt, 7);
      chk("bub_rd1", ex_rd1, 32'h55);
      chk("bub_lu_clear", load_use, 0);
      step();
      chk("post_valid", ex_valid, 1);
      chk("post_wb", ex_wb, 2'b01);
      chk("post_cnt", bubble_cnt, 1);

      // Load to $0 never hazards
      id_mem = 3'b010; id_rt = 5'd0; id_rs = 5'd0;
      step();
      chk("z_lu", load_use, 0);
      step();
      chk("z_valid", ex_valid, 1);
      chk("z_cnt", bubble_cnt, 1);

      // LW rt=9: no match, then match via rt
      id_mem = 3'b010; id_rt = 5'd9; id_rs = 5'd2;
      step();
      id_mem = 3'b000; id_rs = 5'd3; id_rt = 5'd4;
      #1;
      chk("nomatch_lu", load_use, 0);
      id_rs = 5'd1; id_rt = 5'd9; id_rd1 = 32'hAA;
      #1;
      chk("rt_match_lu", load_use, 1);

      // Stall beats flush and load-use for 3 cycles
      stall = 1'b1; flush = 1'b1;
      #1;
      chk("st_pcw", pc_write, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st_mem", ex_mem, 3'b010);
         chk("st_valid", ex_valid, 1);
         chk("st_rt", ex_rt, 9);
         chk("st_rd1", ex_rd1, 32'h55);
         chk("st_cnt", bubble_cnt, 1);
      end
      stall = 1'b0;
      step();
      chk("st_rel_cnt", bubble_cnt, 2);
      chk("st_rel_valid", ex_valid, 0);
      chk("st_rel_mem", ex_mem, 0);
      chk("st_rel_rd1", ex_rd1, 32'hAA);
      flush = 1'b0;

      // X on a control input is latched as 0
      id_wb = 2'bx0; id_mem = 3'b001; id_ex = 4'b0110; id_rt = 5'd10;
      step();
      chk("x_mem", ex_mem, 3'b001);
      chk("x_wb0", ex_wb[0], 0);
      chk("x_known", $isunknown({ex_wb, ex_mem, ex_ex}), 0);
      chk("x_ex", ex_ex, 4'b0110);
      chk("x_valid", ex_valid, 1);

      // Drive counter to FFFE with flushes, then saturate
      id_wb = 2'b01;
      flush = 1'b1;
      repeat (65532) @(posedge clk);
      #1;
      chk("pre_cnt", bubble_cnt, 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("sat_cnt", bubble_cnt, 16'hFFFF);
      end

      // Reset overrides stall mid-bubble
      stall = 1'b1; rst = 1'b1;
      step();
      chk("rs_cnt", bubble_cnt, 0);
      chk("rs_valid", ex_valid, 0);
      chk("rs_wb", ex_wb, 0);
      chk("rs_mem", ex_mem, 0);
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      #1;
      chk("rs_lu", load_use, 0);
      chk("rs_pcw", pc_write, 1);
      chk("rs_ifw", ifid_write, 1);
      step();
      chk("rs_reload_valid", ex_valid, 1);
      chk("rs_reload_wb", ex_wb, 2'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
